// File: rtl/bootram_port_arbiter.sv
// Shares boot-RAM port A between the CPU load path (m0) and the debug loader (m1).
// Round-robin with bounded locked bursts; optional write-protect window via `BOOTRAM_ARB_WPROT_EN.
module bootram_port_arbiter #(
  parameter int ADDR      = 13,
  parameter int DATA      = 16,
  parameter int MAX_BURST = 8
`ifdef BOOTRAM_ARB_WPROT_EN
  ,parameter int unsigned WPROT_TOP = 'h3FF
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            m0_req,
  input  logic            m0_lock,
  input  logic            m0_we,
  input  logic [ADDR-1:0] m0_addr,
  input  logic [DATA-1:0] m0_wdata,
  output logic            m0_ack,
  output logic            m0_rvalid,
  output logic [DATA-1:0] m0_rdata,
  input  logic            m1_req,
  input  logic            m1_lock,
  input  logic            m1_we,
  input  logic [ADDR-1:0] m1_addr,
  input  logic [DATA-1:0] m1_wdata,
  output logic            m1_ack,
  output logic            m1_rvalid,
  output logic [DATA-1:0] m1_rdata,
`ifdef BOOTRAM_ARB_WPROT_EN
  input  logic            wprot,
  output logic            werr,
`endif
  output logic            ram_ce,
  output logic            ram_we,
  output logic [ADDR-1:0] ram_addr,
  output logic [DATA-1:0] ram_write,
  input  logic [DATA-1:0] ram_read
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  state_t          state_q, state_d;
  logic            lock_q, lock_d;
  logic            last_q, last_d;
  logic [7:0]      burst_q, burst_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic [DATA-1:0] wdata_q, wdata_d;
  logic            rd_pend_q, rd_pend_d;
  logic            rd_owner_q, rd_owner_d;
  logic            werr_q, werr_d;

  logic            hold0, hold1, gnt0, gnt1, grant, holdGrant;
  logic            selWe, protHit;
  logic [ADDR-1:0] selAddr;
  logic [DATA-1:0] selWdata;

  always_comb begin
    hold0 = (state_q == OWN0) && lock_q && m0_req && (burst_q < BURST_MAX);
    hold1 = (state_q == OWN1) && lock_q && m1_req && (burst_q < BURST_MAX);
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    // last_q = 1 means m1 was granted last, so m0 wins the next contention
    if (rst_n) begin
      if (hold0)                  gnt0 = 1'b1;
      else if (hold1)             gnt1 = 1'b1;
      else if (m0_req && m1_req) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = m0_req;
        gnt1 = m1_req;
      end
    end
    grant     = gnt0 || gnt1;
    holdGrant = (gnt0 && hold0) || (gnt1 && hold1);
    selWe     = gnt1 ? m1_we    : m0_we;
    selAddr   = gnt1 ? m1_addr  : m0_addr;
    selWdata  = gnt1 ? m1_wdata : m0_wdata;
`ifdef BOOTRAM_ARB_WPROT_EN
    protHit   = wprot && (32'(selAddr) <= WPROT_TOP);
`else
    protHit   = 1'b0;
`endif

    state_d    = gnt0 ? OWN0 : (gnt1 ? OWN1 : IDLE);
    lock_d     = grant && (gnt1 ? m1_lock : m0_lock);
    last_d     = grant ? gnt1 : last_q;
    burst_d    = !grant ? 8'd0 : (holdGrant ? burst_q + 8'd1 : 8'd1);
    addr_d     = grant ? selAddr  : addr_q;
    wdata_d    = grant ? selWdata : wdata_q;
    rd_pend_d  = grant && !selWe;
    rd_owner_d = gnt1;
    werr_d     = grant && selWe && protHit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lock_q     <= 1'b0;
      last_q     <= 1'b1;
      burst_q    <= 8'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
      werr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_q     <= lock_d;
      last_q     <= last_d;
      burst_q    <= burst_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      werr_q     <= werr_d;
    end
  end

  // registered strobes are also masked by rst_n so a reset cancels an in-flight read at once
  assign m0_ack    = gnt0;
  assign m1_ack    = gnt1;
  assign m0_rvalid = rst_n && rd_pend_q && !rd_owner_q;
  assign m1_rvalid = rst_n && rd_pend_q && rd_owner_q;
  assign m0_rdata  = ram_read;
  assign m1_rdata  = ram_read;
  assign ram_ce    = grant;
  assign ram_we    = grant && selWe && !protHit;
  assign ram_addr  = rst_n ? addr_d  : '0;
  assign ram_write = rst_n ? wdata_d : '0;
`ifdef BOOTRAM_ARB_WPROT_EN
  assign werr      = rst_n && werr_q;
`endif

  logic unusedWerr;
  assign unusedWerr = werr_q;

endmodule

// File: tb/tb_bootram_port_arbiter.sv
// Self-checking bench for bootram_port_arbiter: directed steps then randomized traffic
// compared against a transaction-level model of the arbitration rules and RAM contents.
module tb_bootram_port_arbiter;

  localparam int MAXB = 4;

  logic        clk;
  logic        rstN;
  bit          req [2];
  bit          lock [2];
  bit          we [2];
  logic [12:0] addr [2];
  logic [15:0] wdata [2];
  logic        m0Ack, m1Ack, m0Rvalid, m1Rvalid;
  logic [15:0] m0Rdata, m1Rdata;
  logic        ramCe, ramWe;
  logic [12:0] ramAddr;
  logic [15:0] ramWrite;
  logic [15:0] ramRead;
`ifdef BOOTRAM_ARB_WPROT_EN
  logic        wprot;
  logic        werr;
`endif

  bootram_port_arbiter #(
    .ADDR(13), .DATA(16), .MAX_BURST(MAXB)
`ifdef BOOTRAM_ARB_WPROT_EN
    ,.WPROT_TOP('h3FF)
`endif
  ) dut (
    .clk(clk), .rst_n(rstN),
    .m0_req(req[0]), .m0_lock(lock[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_ack(m0Ack), .m0_rvalid(m0Rvalid), .m0_rdata(m0Rdata),
    .m1_req(req[1]), .m1_lock(lock[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_ack(m1Ack), .m1_rvalid(m1Rvalid), .m1_rdata(m1Rdata),
`ifdef BOOTRAM_ARB_WPROT_EN
    .wprot(wprot), .werr(werr),
`endif
    .ram_ce(ramCe), .ram_we(ramWe), .ram_addr(ramAddr), .ram_write(ramWrite), .ram_read(ramRead)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM port A stand-in: registered address, one-cycle read latency
  bit [15:0] mem [8192];
  always @(posedge clk) begin
    if (ramCe && ramWe) mem[ramAddr] <= ramWrite;
    ramRead <= mem[ramAddr];
  end

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  // reference model state
  bit [15:0]   refMem [8192];
  int          prevOwner = -1;
  bit          prevLock  = 0;
  int          burstLen  = 0;
  int          lastWin   = 1;
  logic [12:0] lastAddr  = '0;
  logic [15:0] lastWdata = '0;
  bit          rvPend [2];
  logic [15:0] rdExp     = '0;
  bit          werrPend  = 0;
  int          lastG     = -1;

  logic        obsAck0, obsAck1, obsRamWe, obsRv0, obsRv1, obsWerr;
  logic [15:0] obsRd0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount = checkCount + 1;
    assert (obs === exp) begin
      passCount = passCount + 1;
    end else begin
      failCount = failCount + 1;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs mid-cycle, compare with the model, then advance the model
  task automatic applyStimulus();
    int g;
    bit holdOk;
    bit prot;
    #4;
    holdOk = rstN && (prevOwner >= 0) && prevLock && req[prevOwner] && (burstLen < MAXB);
    g = -1;
    if (!rstN)                g = -1;
    else if (holdOk)          g = prevOwner;
    else if (req[0] && req[1]) g = (lastWin == 0) ? 1 : 0;
    else if (req[0])          g = 0;
    else if (req[1])          g = 1;
    prot = 0;
`ifdef BOOTRAM_ARB_WPROT_EN
    prot = (g >= 0) && wprot && (addr[g] <= 13'h3FF);
`endif
    checkOutput("m0_ack", m0Ack, g == 0);
    checkOutput("m1_ack", m1Ack, g == 1);
    checkOutput("ram_ce", ramCe, g >= 0);
    checkOutput("ram_we", ramWe, (g >= 0) && we[g] && !prot);
    checkOutput("ram_addr", ramAddr, !rstN ? 13'h0 : (g >= 0 ? addr[g] : lastAddr));
    if (g >= 0 && we[g]) checkOutput("ram_write", ramWrite, wdata[g]);
    checkOutput("m0_rvalid", m0Rvalid, rvPend[0] && rstN);
    checkOutput("m1_rvalid", m1Rvalid, rvPend[1] && rstN);
    if (rvPend[0] && rstN) checkOutput("m0_rdata", m0Rdata, rdExp);
    if (rvPend[1] && rstN) checkOutput("m1_rdata", m1Rdata, rdExp);
`ifdef BOOTRAM_ARB_WPROT_EN
    checkOutput("werr", werr, werrPend && rstN);
    obsWerr = werr;
`else
    obsWerr = 1'b0;
`endif
    obsAck0 = m0Ack; obsAck1 = m1Ack; obsRamWe = ramWe;
    obsRv0 = m0Rvalid; obsRv1 = m1Rvalid; obsRd0 = m0Rdata;
    lastG = g;
    if (!rstN) begin
      prevOwner = -1; prevLock = 0; burstLen = 0; lastWin = 1;
      lastAddr = '0; lastWdata = '0; rvPend[0] = 0; rvPend[1] = 0; werrPend = 0;
    end else begin
      rvPend[0] = (g == 0) && !we[0];
      rvPend[1] = (g == 1) && !we[1];
      werrPend  = (g >= 0) && we[g] && prot;
      if (g >= 0) begin
        if (!we[g]) rdExp = refMem[addr[g]];
        else if (!prot) refMem[addr[g]] = wdata[g];
        burstLen  = holdOk ? burstLen + 1 : 1;
        prevOwner = g;
        prevLock  = lock[g];
        lastWin   = g;
        lastAddr  = addr[g];
        lastWdata = wdata[g];
      end else begin
        burstLen = 0; prevOwner = -1; prevLock = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  bit expBurst [6] = '{1, 1, 1, 1, 0, 1};

  initial begin
    rstN = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req[k] = 1; lock[k] = 0; we[k] = 0; addr[k] = 13'(k + 5); wdata[k] = '0;
    end
`ifdef BOOTRAM_ARB_WPROT_EN
    wprot = 1'b0;
`endif
    @(posedge clk);
    #1;

    // reset held with both requesters active
    for (int i = 0; i < 3; i++) applyStimulus();
    rstN = 1'b1;
    applyStimulus();
    checkOutput("first_ack_m0", obsAck0, 1);

    // continuous contention, no lock: strict alternation
    for (int i = 0; i < 6; i++) begin
      addr[0] = 13'($urandom_range(0, 63));
      addr[1] = 13'($urandom_range(0, 63));
      applyStimulus();
      checkOutput("alt_ack0", obsAck0, (i % 2) == 1);
    end

    // locked burst from m1 capped at MAXB grants
    req[1] = 0;
    applyStimulus();
    req[1] = 1; lock[1] = 1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus();
      checkOutput("burst_ack1", obsAck1, expBurst[i]);
    end
    lock[1] = 0; req[1] = 0;

    // read-after-write on m0
    we[0] = 1; addr[0] = 13'h0123; wdata[0] = 16'hBEEF;
    applyStimulus();
    we[0] = 0;
    applyStimulus();
    req[0] = 0;
    applyStimulus();
    checkOutput("raw_rvalid", obsRv0, 1);
    checkOutput("raw_rdata", obsRd0, 16'hBEEF);

    // reset lands right after an m1 read grant
    req[1] = 1; we[1] = 0; addr[1] = 13'h0123;
    applyStimulus();
    rstN = 0; req[1] = 0;
    applyStimulus();
    checkOutput("rst_rvalid1", obsRv1, 0);
    rstN = 1;
    applyStimulus();

`ifdef BOOTRAM_ARB_WPROT_EN
    wprot = 1; req[0] = 1; we[0] = 1; addr[0] = 13'h0010; wdata[0] = 16'h1234;
    applyStimulus();
    checkOutput("wprot_ack", obsAck0, 1);
    checkOutput("wprot_ramwe", obsRamWe, 0);
    addr[0] = 13'h0400;
    applyStimulus();
    checkOutput("wprot_werr", obsWerr, 1);
    checkOutput("wprot_ramwe_hi", obsRamWe, 1);
    req[0] = 0;
    applyStimulus();
    checkOutput("wprot_werr_lo", obsWerr, 0);
    wprot = 0;
`endif

    // randomized traffic with occasional drops and resets
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!req[k] && $urandom_range(0, 2) != 0) begin
          req[k]   = 1;
          we[k]    = ($urandom_range(0, 2) == 0);
          lock[k]  = $urandom_range(0, 1) == 1;
          addr[k]  = ($urandom_range(0, 7) == 0) ? 13'($urandom) : 13'($urandom_range(0, 31));
          wdata[k] = 16'($urandom);
        end else if (req[k] && $urandom_range(0, 15) == 0) begin
          req[k] = 0;
        end
      end
      rstN = ($urandom_range(0, 99) != 0);
`ifdef BOOTRAM_ARB_WPROT_EN
      wprot = $urandom_range(0, 1) == 1;
`endif
      applyStimulus();
      if (lastG >= 0) req[lastG] = 0;
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
